// File: rtl/serial_adder_seq_if.sv
// Operand/result bundle for serial_adder_seq: the requester drives start/a/b/cin,
// and the adder returns busy/done and the held sum/cout/ovf.
interface serial_adder_seq_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: a 1-bit full-adder slice with a registered carry, WIDTH bits LSB-first.
// Define SERIAL_ADD_OVF_EN to build the two's-complement overflow flag; otherwise ovf is 0.
module serial_adder_seq #(
  parameter int unsigned WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  serial_adder_seq_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;

  logic bit_s;
  logic bit_c;
  logic last_bit;

  // Full-adder slice on the current LSBs; c_q closes the loop between bits.
  assign bit_s    = a_q[0] ^ b_q[0] ^ c_q;
  assign bit_c    = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
  assign last_bit = (cnt_q == LastBit);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d = {bit_s, sum_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = bit_c;
        cnt_d = cnt_q + 1'b1;
        if (last_bit) begin
          cout_d  = bit_c;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q, ovf_d;

  // In the final bit c_q is the carry into the MSB and bit_c the carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == StRun && last_bit) begin
      ovf_d = c_q ^ bit_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
